dac_load_sequencer: RTL
=======================

# dac_load_sequencer

Sequences a full load of the 32 SURF threshold DAC channels from the DAC shadow RAM into the four external serial DAC chips. On each update request it reads every channel word from the shadow RAM, frames it as a 24-bit serial command, and shifts it out to the correct chip. It sits between the local-bus register block, which drives `update_i` and consumes `busy_o`, and the DAC RAM read port and DAC pins. It replaces free-running DAC refresh with a single, deterministic sweep.

## Interface
Parameters:
- `SCLK_DIV`, 2: half-period of `dac_sclk_o` in `clk_i` cycles (≥1).
- `CS_GAP`, 2: cycles `dac_ncs_o` is held high between words (≥1).
- `DAC_CMD`, 4'h3: command nibble for "write and update channel n".

Ports:
- `clk_i`, in, 1: system clock (33 MHz local-bus clock).
- `nrst_i`, in, 1: reset, asynchronous, active-low.
- `update_i`, in, 1: single-cycle load request.
- `ram_addr_o`, out, 5: shadow RAM read address, the logical channel 0–31.
- `ram_dat_i`, in, 16: shadow RAM read data, valid 1 cycle after `ram_addr_o`.
- `dac_sclk_o`, out, 1: serial clock; idles low; DAC samples on the rising edge.
- `dac_sdi_o`, out, 1: serial data, MSB first.
- `dac_ncs_o`, out, 4: per-chip chip select, active-low.
- `busy_o`, out, 1: high from the cycle after an accepted request until the sweep ends.
- `done_o`, out, 1: one-cycle pulse at the end of each sweep.

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, GAP.
- IDLE:
  - `update_i`=1 → ch←0, go to FETCH.
- FETCH, 1 cycle:
  - `ram_addr_o`=ch.
- LOAD, 1 cycle:
  - Capture `ram_dat_i` into the shift register as {`DAC_CMD`, 1'b0, ch[2:0], data[15:0]}.
  - Chip index = ch[4:3].
- SHIFT, 24 bits:
  - `dac_ncs_o`[ch[4:3]]=0; the other three chip selects stay 1.
  - Each bit: sclk low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
  - `dac_sdi_o` updates at the start of the low phase.
  - After bit 0's high phase, go to GAP.
- GAP, `CS_GAP` cycles:
  - All chip selects are 1 and sclk is 0.
  - At the end: if ch=31, the sweep is complete; otherwise ch←ch+1 and go to FETCH.
- Sweep complete:
  - `done_o`=1 for one cycle.
  - If pending=1, clear pending, set ch←0 and go to FETCH; `busy_o` stays 1.
  - Otherwise go to IDLE.
- `update_i` while not IDLE sets pending. Multiple requests collapse into one. An in-progress sweep is never restarted.
- Channel counter is 5 bits. The increment past 31 never occurs because completion is checked first.
- Reset, including mid-shift, forces:
  - IDLE; ch=0; pending=0.
  - `dac_ncs_o`=4'hF, `dac_sclk_o`=0, `dac_sdi_o`=0.
  - `busy_o`=0, `done_o`=0, `ram_addr_o`=0.
  - The aborted word is simply truncated, because ncs rises.

## Timing
- Request latency: `update_i` at cycle 0 → FETCH and `busy_o`=1 at cycle 1 → LOAD at cycle 2 → first ncs low at cycle 3.
- Per word: 2 + 48·`SCLK_DIV` + `CS_GAP` cycles. Defaults give 100 cycles.
- Full sweep at defaults is 3200 cycles.
- `done_o` is asserted in the cycle after the last GAP cycle. `busy_o` falls in that same cycle when no request is pending.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Configuration
- `DAC_LOAD_SKIP_UNCHANGED_EN` defined:
  - Adds a 32×16 shadow of the last value sent, plus 32 valid bits that reset clears.
  - In LOAD, if valid[ch] is set and the data equals shadow[ch], SHIFT and GAP are skipped and the next FETCH follows directly. A skipped channel costs 2 cycles.
  - Shadow and valid bits update when bit 0 completes.
- Undefined: every channel is shifted on every sweep, and no shadow storage is built.

## Structure
- Package `dac_seq_pkg` holds:
  - the state enum;
  - the word width (24) and channel count (32);
  - the channels per chip (8);
  - the default `DAC_CMD`.
- Sub-module `dac_spi_shifter` handles the 24-bit serializer and the `SCLK_DIV` divider:
  - inputs: load strobe and word;
  - outputs: sclk, sdi, word-done pulse.
- The sequencer FSM, channel counter, pending flag and chip-select decode live in the top module.

## Test plan
- Reset, then a single `update_i`:
  - `dac_ncs_o` goes low for chip 0 at cycle 3.
  - 32 words are framed as 0x3_c_dddd, and each chip sees 8 words.
  - `done_o` pulses at cycle 3201 and `busy_o` falls in the same cycle.
- RAM preloaded with ch n = 0x1000+n: the word on chip 2 at channel 21 is 24'h351015, shifted MSB first and sampled on sclk rising.
- `update_i` at cycles 500 and 900 during a sweep: the first sweep finishes uninterrupted, `done_o` pulses, then exactly one more sweep runs with `busy_o` continuously high.
- `nrst_i` low mid-SHIFT of channel 7:
  - `dac_ncs_o`=F, sclk=0 and `busy_o`=0 immediately.
  - The next `update_i` restarts at channel 0.
- With `DAC_LOAD_SKIP_UNCHANGED_EN` defined:
  - A second sweep with an unchanged RAM produces no ncs activity and takes 64 cycles.
  - Changing only ch 10 before the sweep produces one word on chip 1.
- `SCLK_DIV`=1, `CS_GAP`=1: the per-word period is 51 cycles, and sclk high and low are each 1 cycle.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the SURF threshold DAC load sequencer.
package dac_seq_pkg;

    localparam int unsigned WORD_W      = 24;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned N_CH        = 32;
    localparam int unsigned CH_PER_CHIP = 8;
    localparam int unsigned N_CHIP      = N_CH / CH_PER_CHIP;
    localparam int unsigned CH_W        = $clog2(N_CH);
    localparam int unsigned CHIP_W      = $clog2(N_CHIP);
    localparam int unsigned SUB_W       = $clog2(CH_PER_CHIP);

    localparam logic [3:0] DAC_CMD_DEFAULT = 4'h3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } seq_state_e;

    // Serial command frame as it leaves the sequencer, MSB first.
    typedef struct packed {
        logic [3:0]        cmd;
        logic              rsvd;
        logic [SUB_W-1:0]  sub;
        logic [DATA_W-1:0] data;
    } dac_word_t;

    function automatic logic [CHIP_W-1:0] chip_of(input logic [CH_W-1:0] ch);
        return ch[CH_W-1 -: CHIP_W];
    endfunction

    function automatic logic [SUB_W-1:0] sub_of(input logic [CH_W-1:0] ch);
        return ch[SUB_W-1:0];
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// 24-bit MSB-first serializer with an SCLK_DIV half-period divider.
// done_o is high during the final high-phase cycle of bit 0.
module dac_spi_shifter
    import dac_seq_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              sclk_o,
    output logic              sdi_o,
    output logic              done_o
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WORD_W);

    logic              active_q, active_d;
    logic              phase_q,  phase_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [BIT_W-1:0]  bit_q,    bit_d;
    logic [WORD_W-1:0] sreg_q,   sreg_d;
    logic              sclk_q,   sclk_d;
    logic              done_q,   done_d;

    // Next-state: low phase then high phase per bit; shifting out zeros leaves sdi low when idle.
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        sclk_d   = sclk_q;
        if (load_i) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            div_d    = '0;
            bit_d    = BIT_W'(WORD_W - 1);
            sreg_d   = word_i;
            sclk_d   = 1'b0;
        end else if (active_q) begin
            if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    sreg_d  = {sreg_q[WORD_W-2:0], 1'b0};
                    if (bit_q == '0) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        done_d = active_d && phase_d && (bit_d == '0) && (div_d == DIV_W'(SCLK_DIV - 1));
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sreg_q   <= '0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sreg_q   <= sreg_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
        end
    end

    assign sclk_o = sclk_q;
    assign sdi_o  = sreg_q[WORD_W-1];
    assign done_o = done_q;

endmodule

// File: rtl/dac_load_sequencer.sv
// Sweeps all 32 threshold DAC channels from the shadow RAM into four serial DAC chips.
// Optional DAC_LOAD_SKIP_UNCHANGED_EN: skip channels whose value matches the last one sent.
module dac_load_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned CS_GAP   = 2,
    parameter logic [3:0]  DAC_CMD  = DAC_CMD_DEFAULT
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              update_i,
    output logic [CH_W-1:0]   ram_addr_o,
    input  logic [DATA_W-1:0] ram_dat_i,
    output logic              dac_sclk_o,
    output logic              dac_sdi_o,
    output logic [N_CHIP-1:0] dac_ncs_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    seq_state_e        state_q;
    logic [CH_W-1:0]   ch_q;
    logic              pending_q;
    logic              busy_q;
    logic              done_q;
    logic [N_CHIP-1:0] ncs_q;
    logic [GAP_W-1:0]  gap_q;

    logic      skip_c;
    logic      load_c;
    logic      gap_last_c;
    logic      adv_c;
    logic      word_done;
    dac_word_t word_c;

    always_comb begin
        word_c      = '0;
        word_c.cmd  = DAC_CMD;
        word_c.rsvd = 1'b0;
        word_c.sub  = sub_of(ch_q);
        word_c.data = ram_dat_i;
    end

`ifdef DAC_LOAD_SKIP_UNCHANGED_EN
    logic [DATA_W-1:0] shadow_q [N_CH];
    logic [N_CH-1:0]   valid_q;
    logic [DATA_W-1:0] data_q;

    assign skip_c = valid_q[ch_q] && (shadow_q[ch_q] == ram_dat_i);

    // A channel only counts as sent once its last bit has been clocked out.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            if (state_q == S_LOAD) data_q <= ram_dat_i;
            if (state_q == S_SHIFT && word_done) valid_q[ch_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_SHIFT && word_done) shadow_q[ch_q] <= data_q;
    end
`else
    assign skip_c = 1'b0;
`endif

    assign load_c     = (state_q == S_LOAD) && !skip_c;
    assign gap_last_c = (gap_q == GAP_W'(CS_GAP - 1));
    assign adv_c      = ((state_q == S_LOAD) && skip_c) || ((state_q == S_GAP) && gap_last_c);

    dac_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .load_i (load_c),
        .word_i (word_c),
        .sclk_o (dac_sclk_o),
        .sdi_o  (dac_sdi_o),
        .done_o (word_done)
    );

    // Sequencer: channel walk, pending-request collapse and chip-select decode.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ncs_q     <= '1;
            gap_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (update_i && state_q != S_IDLE) pending_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (update_i) begin
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    if (!skip_c) begin
                        ncs_q   <= ~(N_CHIP'(1) << chip_of(ch_q));
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (word_done) begin
                        ncs_q   <= '1;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!gap_last_c) gap_q <= gap_q + GAP_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            // Completion is tested before the increment, so ch never wraps.
            if (adv_c) begin
                if (ch_q == CH_W'(N_CH - 1)) begin
                    done_q    <= 1'b1;
                    pending_q <= 1'b0;
                    if (pending_q || update_i) begin
                        ch_q    <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end else begin
                    ch_q    <= ch_q + CH_W'(1);
                    state_q <= S_FETCH;
                end
            end
        end
    end

    assign ram_addr_o = ch_q;
    assign dac_ncs_o  = ncs_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
